// File: rtl/rom_access_arbiter.sv
// PSRAM access sequencer: arbitrates SNES (decoded) and MCU byte accesses onto one PSRAM.
// Optional SNES write protection is enabled by defining ROM_WRPROT_EN.
module rom_access_arbiter #(
    parameter int RD_WAIT = 5,
    parameter int WR_WAIT = 5
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        SNES_RD_START,
    input  logic        SNES_WR_START,
    input  logic [23:0] SNES_ROM_ADDR,
    input  logic        SNES_ROM_HIT,
    input  logic        SNES_WRITABLE,
    input  logic [7:0]  SNES_DATA_IN,
    output logic [7:0]  SNES_DATA_OUT,
    input  logic        MCU_RRQ,
    input  logic        MCU_WRQ,
    input  logic [23:0] MCU_ADDR,
    input  logic [7:0]  MCU_DOUT,
    output logic [7:0]  MCU_DIN,
    output logic        MCU_RDY,
    output logic [23:0] PSRAM_ADDR,
    input  logic [7:0]  PSRAM_DQ_IN,
    output logic [7:0]  PSRAM_DQ_OUT,
    output logic        PSRAM_DQ_OE,
    output logic        PSRAM_CE_N,
    output logic        PSRAM_OE_N,
    output logic        PSRAM_WE_N,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SNES_RD = 3'd1,
        SNES_WR = 3'd2,
        MCU_RD  = 3'd3,
        MCU_WR  = 3'd4
    } state_t;

    localparam logic [3:0] RD_WAIT_C = 4'(RD_WAIT);
    localparam logic [3:0] WR_WAIT_C = 4'(WR_WAIT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        snes_pend_q, snes_pend_d;
    logic        snes_is_wr_q, snes_is_wr_d;
    logic [23:0] snes_addr_q, snes_addr_d;
    logic [7:0]  snes_data_q, snes_data_d;

    logic        mcu_pend_q, mcu_pend_d;
    logic        mcu_is_wr_q, mcu_is_wr_d;
    logic [23:0] mcu_addr_q, mcu_addr_d;
    logic [7:0]  mcu_data_q, mcu_data_d;

    logic [23:0] psram_addr_q, psram_addr_d;
    logic [7:0]  dq_out_q, dq_out_d;
    logic        dq_oe_q, dq_oe_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic [7:0]  snes_dout_q, snes_dout_d;
    logic [7:0]  mcu_din_q, mcu_din_d;
    logic        mcu_rdy_q, mcu_rdy_d;
    logic        busy_q, busy_d;

    logic        snes_start;
    logic        mcu_start;
    logic        snes_rd_ok;
    logic        snes_wr_ok;

`ifdef ROM_WRPROT_EN
    assign snes_wr_ok = SNES_WR_START & SNES_ROM_HIT & SNES_WRITABLE;
`else
    logic unused_writable;
    assign unused_writable = SNES_WRITABLE;
    assign snes_wr_ok = SNES_WR_START & SNES_ROM_HIT;
`endif
    assign snes_rd_ok = SNES_RD_START & SNES_ROM_HIT;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        psram_addr_d = psram_addr_q;
        dq_out_d     = dq_out_q;
        dq_oe_d      = dq_oe_q;
        ce_n_d       = ce_n_q;
        oe_n_d       = oe_n_q;
        we_n_d       = we_n_q;
        snes_dout_d  = snes_dout_q;
        mcu_din_d    = mcu_din_q;
        mcu_rdy_d    = 1'b0;
        snes_start   = 1'b0;
        mcu_start    = 1'b0;

        // Strobes are computed from the next state so they change on the same edge as the state.
        case (state_q)
            IDLE: begin
                if (snes_pend_q) begin
                    snes_start   = 1'b1;
                    psram_addr_d = snes_addr_q;
                    ce_n_d       = 1'b0;
                    if (snes_is_wr_q) begin
                        state_d  = SNES_WR;
                        cnt_d    = WR_WAIT_C;
                        we_n_d   = 1'b0;
                        dq_oe_d  = 1'b1;
                        dq_out_d = snes_data_q;
                    end else begin
                        state_d  = SNES_RD;
                        cnt_d    = RD_WAIT_C;
                        oe_n_d   = 1'b0;
                    end
                end else if (mcu_pend_q) begin
                    mcu_start    = 1'b1;
                    psram_addr_d = mcu_addr_q;
                    ce_n_d       = 1'b0;
                    if (mcu_is_wr_q) begin
                        state_d  = MCU_WR;
                        cnt_d    = WR_WAIT_C;
                        we_n_d   = 1'b0;
                        dq_oe_d  = 1'b1;
                        dq_out_d = mcu_data_q;
                    end else begin
                        state_d  = MCU_RD;
                        cnt_d    = RD_WAIT_C;
                        oe_n_d   = 1'b0;
                    end
                end
            end
            SNES_RD, SNES_WR, MCU_RD, MCU_WR: begin
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    dq_oe_d = 1'b0;
                    if (state_q == SNES_RD) begin
                        snes_dout_d = PSRAM_DQ_IN;
                    end
                    if (state_q == MCU_RD) begin
                        mcu_din_d = PSRAM_DQ_IN;
                    end
                    if ((state_q == MCU_RD) || (state_q == MCU_WR)) begin
                        mcu_rdy_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
                dq_oe_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // SNES slot: newest accepted pulse overwrites; read beats a simultaneous write.
    always_comb begin
        snes_pend_d  = snes_pend_q & ~snes_start;
        snes_is_wr_d = snes_is_wr_q;
        snes_addr_d  = snes_addr_q;
        snes_data_d  = snes_data_q;
        if (snes_rd_ok) begin
            snes_pend_d  = 1'b1;
            snes_is_wr_d = 1'b0;
            snes_addr_d  = SNES_ROM_ADDR;
            snes_data_d  = SNES_DATA_IN;
        end else if (snes_wr_ok) begin
            snes_pend_d  = 1'b1;
            snes_is_wr_d = 1'b1;
            snes_addr_d  = SNES_ROM_ADDR;
            snes_data_d  = SNES_DATA_IN;
        end
    end

    // MCU slot: first request wins until it has been started.
    always_comb begin
        mcu_pend_d  = mcu_pend_q & ~mcu_start;
        mcu_is_wr_d = mcu_is_wr_q;
        mcu_addr_d  = mcu_addr_q;
        mcu_data_d  = mcu_data_q;
        if ((MCU_RRQ | MCU_WRQ) && !mcu_pend_d) begin
            mcu_pend_d  = 1'b1;
            mcu_is_wr_d = ~MCU_RRQ;
            mcu_addr_d  = MCU_ADDR;
            mcu_data_d  = MCU_DOUT;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            snes_pend_q  <= 1'b0;
            snes_is_wr_q <= 1'b0;
            snes_addr_q  <= 24'd0;
            snes_data_q  <= 8'd0;
            mcu_pend_q   <= 1'b0;
            mcu_is_wr_q  <= 1'b0;
            mcu_addr_q   <= 24'd0;
            mcu_data_q   <= 8'd0;
            psram_addr_q <= 24'd0;
            dq_out_q     <= 8'd0;
            dq_oe_q      <= 1'b0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            snes_dout_q  <= 8'd0;
            mcu_din_q    <= 8'd0;
            mcu_rdy_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            snes_pend_q  <= snes_pend_d;
            snes_is_wr_q <= snes_is_wr_d;
            snes_addr_q  <= snes_addr_d;
            snes_data_q  <= snes_data_d;
            mcu_pend_q   <= mcu_pend_d;
            mcu_is_wr_q  <= mcu_is_wr_d;
            mcu_addr_q   <= mcu_addr_d;
            mcu_data_q   <= mcu_data_d;
            psram_addr_q <= psram_addr_d;
            dq_out_q     <= dq_out_d;
            dq_oe_q      <= dq_oe_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            snes_dout_q  <= snes_dout_d;
            mcu_din_q    <= mcu_din_d;
            mcu_rdy_q    <= mcu_rdy_d;
            busy_q       <= busy_d;
        end
    end

    assign SNES_DATA_OUT = snes_dout_q;
    assign MCU_DIN       = mcu_din_q;
    assign MCU_RDY       = mcu_rdy_q;
    assign PSRAM_ADDR    = psram_addr_q;
    assign PSRAM_DQ_OUT  = dq_out_q;
    assign PSRAM_DQ_OE   = dq_oe_q;
    assign PSRAM_CE_N    = ce_n_q;
    assign PSRAM_OE_N    = oe_n_q;
    assign PSRAM_WE_N    = we_n_q;
    assign BUSY          = busy_q;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter: vector table of single SNES accesses plus
// hand-written multi-cycle sequences (arbitration, overwrite, mid-cycle reset).
module tb_rom_access_arbiter;

    localparam int RD_W = 5;
    localparam int WR_W = 5;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        SNES_RD_START = 1'b0;
    logic        SNES_WR_START = 1'b0;
    logic [23:0] SNES_ROM_ADDR = 24'd0;
    logic        SNES_ROM_HIT = 1'b0;
    logic        SNES_WRITABLE = 1'b0;
    logic [7:0]  SNES_DATA_IN = 8'd0;
    logic [7:0]  SNES_DATA_OUT;
    logic        MCU_RRQ = 1'b0;
    logic        MCU_WRQ = 1'b0;
    logic [23:0] MCU_ADDR = 24'd0;
    logic [7:0]  MCU_DOUT = 8'd0;
    logic [7:0]  MCU_DIN;
    logic        MCU_RDY;
    logic [23:0] PSRAM_ADDR;
    logic [7:0]  PSRAM_DQ_IN = 8'd0;
    logic [7:0]  PSRAM_DQ_OUT;
    logic        PSRAM_DQ_OE;
    logic        PSRAM_CE_N;
    logic        PSRAM_OE_N;
    logic        PSRAM_WE_N;
    logic        BUSY;

    rom_access_arbiter #(.RD_WAIT(RD_W), .WR_WAIT(WR_W)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .SNES_RD_START(SNES_RD_START), .SNES_WR_START(SNES_WR_START),
        .SNES_ROM_ADDR(SNES_ROM_ADDR), .SNES_ROM_HIT(SNES_ROM_HIT),
        .SNES_WRITABLE(SNES_WRITABLE), .SNES_DATA_IN(SNES_DATA_IN),
        .SNES_DATA_OUT(SNES_DATA_OUT),
        .MCU_RRQ(MCU_RRQ), .MCU_WRQ(MCU_WRQ), .MCU_ADDR(MCU_ADDR),
        .MCU_DOUT(MCU_DOUT), .MCU_DIN(MCU_DIN), .MCU_RDY(MCU_RDY),
        .PSRAM_ADDR(PSRAM_ADDR), .PSRAM_DQ_IN(PSRAM_DQ_IN),
        .PSRAM_DQ_OUT(PSRAM_DQ_OUT), .PSRAM_DQ_OE(PSRAM_DQ_OE),
        .PSRAM_CE_N(PSRAM_CE_N), .PSRAM_OE_N(PSRAM_OE_N),
        .PSRAM_WE_N(PSRAM_WE_N), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        hit;
        logic        wrt;
        logic [23:0] addr;
        logic [7:0]  din;
        logic [7:0]  dq;
        int          exp_oe;
        int          exp_we;
        logic [7:0]  exp_dout;
    } vec_t;

    vec_t       tbl[6];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] prev_dout = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int oe_lo, we_lo, first_lo, addr_bad, dq_bad, busy_end;
        oe_lo = 0; we_lo = 0; first_lo = 0; addr_bad = 0; dq_bad = 0; busy_end = 1;
        SNES_RD_START = v.rd;
        SNES_WR_START = v.wr;
        SNES_ROM_HIT  = v.hit;
        SNES_WRITABLE = v.wrt;
        SNES_ROM_ADDR = v.addr;
        SNES_DATA_IN  = v.din;
        PSRAM_DQ_IN   = v.dq;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) begin
                SNES_RD_START = 1'b0;
                SNES_WR_START = 1'b0;
            end
            if (!PSRAM_OE_N) oe_lo++;
            if (!PSRAM_WE_N) we_lo++;
            if (!PSRAM_CE_N && first_lo == 0) first_lo = c;
            if (!PSRAM_CE_N && PSRAM_ADDR !== v.addr) addr_bad++;
            if (!PSRAM_WE_N && (PSRAM_DQ_OUT !== v.din || !PSRAM_DQ_OE)) dq_bad++;
            if (PSRAM_WE_N && PSRAM_DQ_OE) dq_bad++;
            if (c == 6) chk($sformatf("v%0d_dout_before", idx), 32'(SNES_DATA_OUT), 32'(prev_dout));
            if (c == 7) chk($sformatf("v%0d_dout_after", idx), 32'(SNES_DATA_OUT), 32'(v.exp_dout));
            if (c == 12) busy_end = int'(BUSY);
        end
        chk($sformatf("v%0d_oe_cycles", idx), 32'(oe_lo), 32'(v.exp_oe));
        chk($sformatf("v%0d_we_cycles", idx), 32'(we_lo), 32'(v.exp_we));
        chk($sformatf("v%0d_first_strobe", idx), 32'(first_lo),
            ((v.exp_oe + v.exp_we) > 0) ? 32'd2 : 32'd0);
        chk($sformatf("v%0d_addr_bad", idx), 32'(addr_bad), 32'd0);
        chk($sformatf("v%0d_dq_bad", idx), 32'(dq_bad), 32'd0);
        chk($sformatf("v%0d_busy_end", idx), 32'(busy_end), 32'd0);
        prev_dout = v.exp_dout;
    endtask

    initial begin
        int we_lo, oe_lo, rdy_cnt, busy_cnt, bad;

        //         rd    wr    hit   wrt   addr          din    dq     oe    we    dout
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 24'h123456, 8'h00, 8'hA5, RD_W, 0,    8'hA5};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h222222, 8'h00, 8'h44, 0,    0,    8'hA5};
`ifdef ROM_WRPROT_EN
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 24'hE00004, 8'h77, 8'h00, 0,    0,    8'hA5};
`else
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 24'hE00004, 8'h77, 8'h00, 0,    WR_W, 8'hA5};
`endif
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 24'h00ABCD, 8'h5A, 8'h00, 0,    WR_W, 8'hA5};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 24'h0F0F0F, 8'h81, 8'h3C, RD_W, 0,    8'h3C};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 24'hFFFFFF, 8'h00, 8'hFF, RD_W, 0,    8'hFF};

        // Reset state
        tick();
        tick();
        chk("rst_ce_n", 32'(PSRAM_CE_N), 32'd1);
        chk("rst_oe_n", 32'(PSRAM_OE_N), 32'd1);
        chk("rst_we_n", 32'(PSRAM_WE_N), 32'd1);
        chk("rst_dq_oe", 32'(PSRAM_DQ_OE), 32'd0);
        chk("rst_addr", 32'(PSRAM_ADDR), 32'd0);
        chk("rst_dq_out", 32'(PSRAM_DQ_OUT), 32'd0);
        chk("rst_snes_dout", 32'(SNES_DATA_OUT), 32'd0);
        chk("rst_mcu_din", 32'(MCU_DIN), 32'd0);
        chk("rst_mcu_rdy", 32'(MCU_RDY), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        RST_N = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

        // MCU write, SNES read arrives two cycles later and waits
        MCU_ADDR = 24'h000010; MCU_DOUT = 8'h3C; MCU_WRQ = 1'b1; PSRAM_DQ_IN = 8'h5E;
        we_lo = 0; rdy_cnt = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 1) MCU_WRQ = 1'b0;
            if (c == 2) begin
                SNES_ROM_ADDR = 24'h000123; SNES_ROM_HIT = 1'b1; SNES_RD_START = 1'b1;
            end
            if (c == 3) SNES_RD_START = 1'b0;
            if (!PSRAM_WE_N) we_lo++;
            if (MCU_RDY) rdy_cnt++;
            if (c == 2) chk("b_wr_addr", 32'(PSRAM_ADDR), 32'h10);
            if (c == 2) chk("b_wr_data", 32'(PSRAM_DQ_OUT), 32'h3C);
            if (c == 7) chk("b_mcu_rdy", 32'(MCU_RDY), 32'd1);
            if (c == 7) chk("b_idle_ce_n", 32'(PSRAM_CE_N), 32'd1);
            if (c == 7) chk("b_idle_busy", 32'(BUSY), 32'd0);
            if (c == 8) chk("b_rd_oe_n", 32'(PSRAM_OE_N), 32'd0);
            if (c == 8) chk("b_rd_addr", 32'(PSRAM_ADDR), 32'h123);
            if (c == 12) chk("b_dout_before", 32'(SNES_DATA_OUT), 32'(prev_dout));
            if (c == 13) chk("b_dout_after", 32'(SNES_DATA_OUT), 32'h5E);
        end
        chk("b_we_cycles", 32'(we_lo), 32'(WR_W));
        chk("b_rdy_count", 32'(rdy_cnt), 32'd1);
        prev_dout = 8'h5E;

        // Simultaneous SNES read+write with a pending MCU read
        MCU_ADDR = 24'h0000AA; MCU_RRQ = 1'b1;
        SNES_ROM_ADDR = 24'h000055; SNES_ROM_HIT = 1'b1; SNES_DATA_IN = 8'h99;
        SNES_RD_START = 1'b1; SNES_WR_START = 1'b1; PSRAM_DQ_IN = 8'h11;
        we_lo = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 1) begin
                MCU_RRQ = 1'b0; SNES_RD_START = 1'b0; SNES_WR_START = 1'b0;
            end
            if (c == 7) PSRAM_DQ_IN = 8'h22;
            if (!PSRAM_WE_N) we_lo++;
            if (c == 2) chk("c_snes_addr", 32'(PSRAM_ADDR), 32'h55);
            if (c == 2) chk("c_snes_oe_n", 32'(PSRAM_OE_N), 32'd0);
            if (c == 7) chk("c_snes_dout", 32'(SNES_DATA_OUT), 32'h11);
            if (c == 8) chk("c_mcu_addr", 32'(PSRAM_ADDR), 32'hAA);
            if (c == 8) chk("c_mcu_oe_n", 32'(PSRAM_OE_N), 32'd0);
            if (c == 13) chk("c_mcu_din", 32'(MCU_DIN), 32'h22);
            if (c == 13) chk("c_mcu_rdy", 32'(MCU_RDY), 32'd1);
        end
        chk("c_no_write", 32'(we_lo), 32'd0);
        prev_dout = 8'h11;

        // Two SNES reads during an MCU read: only the newer address is served
        MCU_ADDR = 24'h000040; MCU_RRQ = 1'b1; PSRAM_DQ_IN = 8'h66;
        oe_lo = 0; bad = 0; busy_cnt = 0;
        for (int c = 1; c <= 18; c++) begin
            tick();
            if (c == 1) MCU_RRQ = 1'b0;
            if (c == 3) begin SNES_ROM_ADDR = 24'h000100; SNES_RD_START = 1'b1; end
            if (c == 4) SNES_ROM_ADDR = 24'h000200;
            if (c == 5) SNES_RD_START = 1'b0;
            if (!PSRAM_OE_N) oe_lo++;
            if (!PSRAM_OE_N && c >= 8 && PSRAM_ADDR !== 24'h000200) bad++;
            if (c >= 14 && BUSY) busy_cnt++;
            if (c == 8) chk("d_addr", 32'(PSRAM_ADDR), 32'h200);
            if (c == 13) chk("d_dout", 32'(SNES_DATA_OUT), 32'h66);
        end
        chk("d_oe_cycles", 32'(oe_lo), 32'(2 * RD_W));
        chk("d_addr_bad", 32'(bad), 32'd0);
        chk("d_no_third_cycle", 32'(busy_cnt), 32'd0);
        prev_dout = 8'h66;

        // Reset in the middle of an MCU read with a SNES read pending
        MCU_ADDR = 24'h000077; MCU_RRQ = 1'b1; PSRAM_DQ_IN = 8'h99;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) MCU_RRQ = 1'b0;
            if (c == 3) begin SNES_ROM_ADDR = 24'h000300; SNES_RD_START = 1'b1; end
        end
        SNES_RD_START = 1'b0;
        chk("e_pre_oe_n", 32'(PSRAM_OE_N), 32'd0);
        RST_N = 1'b0;
        #1;
        chk("e_rst_ce_n", 32'(PSRAM_CE_N), 32'd1);
        chk("e_rst_oe_n", 32'(PSRAM_OE_N), 32'd1);
        chk("e_rst_dq_oe", 32'(PSRAM_DQ_OE), 32'd0);
        chk("e_rst_busy", 32'(BUSY), 32'd0);
        tick();
        tick();
        RST_N = 1'b1;
        rdy_cnt = 0; busy_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (MCU_RDY) rdy_cnt++;
            if (BUSY) busy_cnt++;
        end
        chk("e_no_rdy", 32'(rdy_cnt), 32'd0);
        chk("e_pending_cleared", 32'(busy_cnt), 32'd0);
        chk("e_mcu_din", 32'(MCU_DIN), 32'd0);
        chk("e_snes_dout", 32'(SNES_DATA_OUT), 32'd0);
        prev_dout = 8'h00;
        run_vec(tbl[0], 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
